// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU data-memory arbiter slice.
package cpu_mem_pkg;

   localparam int          ADDR_W_DEFAULT    = 8;
   localparam int          DATA_W_DEFAULT    = 8;
   localparam int unsigned MEM_DEPTH_DEFAULT = 100;

   localparam logic PORT_IFU = 1'b0;
   localparam logic PORT_LSU = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker; the last-grant register moves only when a grant is taken.
module arb_rr2
   import cpu_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic       grant_o
);

   logic lastGrant_q;
   logic lastGrant_d;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      grant_o     = PORT_IFU;
      lastGrant_d = lastGrant_q;
      if (req_i == 2'b11) begin
         grant_o = ~lastGrant_q;
      end else if (req_i[1]) begin
         grant_o = PORT_LSU;
      end
      if (update_i) begin
         lastGrant_d = grant_o;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrant_q <= PORT_LSU;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data memory between instruction fetch (port 0) and load/store (port 1).
module mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int          ADDR_W    = ADDR_W_DEFAULT,
   parameter int          DATA_W    = DATA_W_DEFAULT,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic              p0_err,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p1_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_operation,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        state_q, state_d;
   logic              winner_q, winner_d;
   logic              we_q, we_d;
   logic              inRange_q, inRange_d;
   logic [ADDR_W-1:0] memAddress_q, memAddress_d;
   logic              memOp_q, memOp_d;
   logic [DATA_W-1:0] memWdata_q, memWdata_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        err_q, err_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              grant;
   logic              grantTaken;
   logic              selWe;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selWdata;
   logic              selInRange;
   logic [DATA_W-1:0] readValue;

   arb_rr2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_i    ({p1_req, p0_req}),
      .update_i (grantTaken),
      .grant_o  (grant)
   );

   assign selWe      = (grant == PORT_LSU) ? p1_we    : p0_we;
   assign selAddr    = (grant == PORT_LSU) ? p1_addr  : p0_addr;
   assign selWdata   = (grant == PORT_LSU) ? p1_wdata : p0_wdata;
   assign selInRange = (32'(selAddr) < MEM_DEPTH);
   assign readValue  = inRange_q ? mem_rdata : '0;

   // memOp defaults low so the memory sees a write strobe only during ACCESS;
   // out-of-range commands never reach the memory and read back as zero.
   always_comb begin
      state_d      = state_q;
      winner_d     = winner_q;
      we_d         = we_q;
      inRange_d    = inRange_q;
      memAddress_d = memAddress_q;
      memOp_d      = 1'b0;
      memWdata_d   = memWdata_q;
      ack_d        = '0;
      err_d        = '0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      grantTaken   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               grantTaken   = 1'b1;
               winner_d     = grant;
               we_d         = selWe;
               inRange_d    = selInRange;
               memAddress_d = selInRange ? selAddr : '0;
               memOp_d      = selWe & selInRange;
               memWdata_d   = selWdata;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            ack_d[winner_q] = 1'b1;
            err_d[winner_q] = ~inRange_q;
            if (!we_q) begin
               if (winner_q == PORT_LSU) begin
                  rdata1_d = readValue;
               end else begin
                  rdata0_d = readValue;
               end
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         winner_q     <= PORT_IFU;
         we_q         <= 1'b0;
         inRange_q    <= 1'b0;
         memAddress_q <= '0;
         memOp_q      <= 1'b0;
         memWdata_q   <= '0;
         ack_q        <= '0;
         err_q        <= '0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         state_q      <= state_d;
         winner_q     <= winner_d;
         we_q         <= we_d;
         inRange_q    <= inRange_d;
         memAddress_q <= memAddress_d;
         memOp_q      <= memOp_d;
         memWdata_q   <= memWdata_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   assign p0_ack        = ack_q[0];
   assign p1_ack        = ack_q[1];
   assign p0_err        = err_q[0];
   assign p1_err        = err_q[1];
   assign p0_rdata      = rdata0_q;
   assign p1_rdata      = rdata1_q;
   assign mem_address   = memAddress_q;
   assign mem_operation = memOp_q;
   assign mem_wdata     = memWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, per-port requester agents, and a transaction-level scoreboard.
module tb_mem_arbiter;

   localparam int DEPTH = 100;

   typedef struct {
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } cmd_t;

   typedef struct {
      int          port;
      int unsigned ackEdge;
      bit          isRead;
      bit          err;
      logic [7:0]  data;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       p0_req = 1'b0, p0_we = 1'b0;
   logic [7:0] p0_addr = '0, p0_wdata = '0;
   logic       p1_req = 1'b0, p1_we = 1'b0;
   logic [7:0] p1_addr = '0, p1_wdata = '0;
   logic       p0_ack, p0_err, p1_ack, p1_err;
   logic [7:0] p0_rdata, p1_rdata;
   logic [7:0] mem_address, mem_wdata;
   logic       mem_operation;
   logic [7:0] mem_rdata = '0;

   logic [7:0]  memArr [0:255];
   logic [7:0]  refMem [0:255];
   cmd_t        q0[$], q1[$];
   exp_t        pend[$];
   int          ackPort[$];
   int unsigned ackEdgeLog[$];
   logic [7:0]  expRd [0:1];

   int          checkCount = 0;
   int          failCount = 0;
   int unsigned edgeCnt = 0;
   int unsigned busyUntil = 0;
   bit          lastWin = 1'b1;
   bit          expOpNow = 1'b0;
   logic [7:0]  expOpAddr = '0, expOpData = '0;
   bit          checkEn = 1'b0;
   bit          gapEn = 1'b0;
   bit          ackSeen0 = 1'b0, ackSeen1 = 1'b0;
   int          opCount = 0;

   mem_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .p0_req        (p0_req),
      .p0_we         (p0_we),
      .p0_addr       (p0_addr),
      .p0_wdata      (p0_wdata),
      .p0_ack        (p0_ack),
      .p0_rdata      (p0_rdata),
      .p0_err        (p0_err),
      .p1_req        (p1_req),
      .p1_we         (p1_we),
      .p1_addr       (p1_addr),
      .p1_wdata      (p1_wdata),
      .p1_ack        (p1_ack),
      .p1_rdata      (p1_rdata),
      .p1_err        (p1_err),
      .mem_address   (mem_address),
      .mem_operation (mem_operation),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input int port, input bit we, input logic [7:0] addr, input logic [7:0] wdata);
      cmd_t c;
      c.we = we;
      c.addr = addr;
      c.wdata = wdata;
      if (port == 0) q0.push_back(c);
      else q1.push_back(c);
   endtask

   task automatic waitDrain(input int maxCycles);
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || p0_req || p1_req) && n < maxCycles) begin
         @(posedge clk);
         n++;
      end
      if (n >= maxCycles) begin
         checkOutput("drainTimeout", 1, 0);
         q0.delete();
         q1.delete();
         p0_req = 1'b0;
         p1_req = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic applyReset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Memory: writes and read-data updates both happen on the falling edge.
   always @(negedge clk) begin
      if (mem_operation) memArr[mem_address] <= mem_wdata;
      mem_rdata <= memArr[mem_address];
   end

   // Requester agents: hold a command until its ack, then offer the next one.
   always @(posedge clk) begin
      cmd_t c;
      #1;
      if (ackSeen0) begin p0_req = 1'b0; ackSeen0 = 1'b0; end
      if (ackSeen1) begin p1_req = 1'b0; ackSeen1 = 1'b0; end
      if (!p0_req && q0.size() != 0 && (!gapEn || $urandom_range(0, 3) != 0)) begin
         c = q0.pop_front();
         p0_req = 1'b1; p0_we = c.we; p0_addr = c.addr; p0_wdata = c.wdata;
      end
      if (!p1_req && q1.size() != 0 && (!gapEn || $urandom_range(0, 3) != 0)) begin
         c = q1.pop_front();
         p1_req = 1'b1; p1_we = c.we; p1_addr = c.addr; p1_wdata = c.wdata;
      end
   end

   // Reference: a grant holds the memory for three edges and is acked one edge after it is taken.
   always @(posedge clk) begin
      exp_t e;
      bit   win;
      bit   we;
      logic [7:0] a, d;
      edgeCnt++;
      expOpNow = 1'b0;
      if (reset) begin
         pend.delete();
         busyUntil = 0;
         lastWin = 1'b1;
         expRd[0] = '0;
         expRd[1] = '0;
      end else if (edgeCnt >= busyUntil && (p0_req || p1_req)) begin
         if (p0_req && p1_req) win = ~lastWin;
         else win = p1_req;
         lastWin = win;
         we = win ? p1_we : p0_we;
         a  = win ? p1_addr : p0_addr;
         d  = win ? p1_wdata : p0_wdata;
         e.port = int'(win);
         e.ackEdge = edgeCnt + 1;
         e.isRead = !we;
         e.err = (a >= DEPTH);
         e.data = (a < DEPTH) ? refMem[a] : 8'h00;
         if (we && a < DEPTH) begin
            refMem[a] = d;
            expOpNow = 1'b1;
            expOpAddr = a;
            expOpData = d;
         end
         pend.push_back(e);
         busyUntil = edgeCnt + 3;
      end
   end

   always @(negedge clk) begin
      exp_t t;
      bit   e0;
      bit   e1;
      if (checkEn) begin
         e0 = 1'b0;
         e1 = 1'b0;
         if (pend.size() != 0 && pend[0].ackEdge == edgeCnt) begin
            t = pend.pop_front();
            if (t.port == 0) e0 = 1'b1; else e1 = 1'b1;
            if (t.isRead) expRd[t.port] = t.data;
         end
         checkOutput("ack0", p0_ack, e0);
         checkOutput("ack1", p1_ack, e1);
         if (e0) checkOutput("err0", p0_err, t.err);
         if (e1) checkOutput("err1", p1_err, t.err);
         checkOutput("rdata0", p0_rdata, expRd[0]);
         checkOutput("rdata1", p1_rdata, expRd[1]);
         checkOutput("memOp", mem_operation, expOpNow);
         if (expOpNow) begin
            checkOutput("memAddr", mem_address, expOpAddr);
            checkOutput("memWdata", mem_wdata, expOpData);
         end
      end
      if (mem_operation === 1'b1) opCount++;
      if (p0_ack === 1'b1) begin ackSeen0 = 1'b1; ackPort.push_back(0); ackEdgeLog.push_back(edgeCnt); end
      if (p1_ack === 1'b1) begin ackSeen1 = 1'b1; ackPort.push_back(1); ackEdgeLog.push_back(edgeCnt); end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [7:0] saved0;
      int n;
      for (int a = 0; a < 256; a++) begin
         v = 8'($urandom);
         memArr[a] = v;
         refMem[a] = v;
      end
      repeat (2) @(posedge clk);
      #2;
      checkEn = 1'b1;
      checkOutput("rstAck0", p0_ack, 0);
      checkOutput("rstAck1", p1_ack, 0);
      checkOutput("rstErr0", p0_err, 0);
      checkOutput("rstErr1", p1_err, 0);
      checkOutput("rstRdata0", p0_rdata, 0);
      checkOutput("rstRdata1", p1_rdata, 0);
      checkOutput("rstMemAddr", mem_address, 0);
      checkOutput("rstMemOp", mem_operation, 0);
      checkOutput("rstMemWdata", mem_wdata, 0);

      // Simultaneous first requests: port 0 wins the first tie.
      ackPort.delete(); ackEdgeLog.delete();
      applyStimulus(0, 1'b0, 8'd3, 8'h00);
      applyStimulus(1, 1'b1, 8'd7, 8'h3C);
      reset = 1'b0;
      waitDrain(100);
      checkOutput("tieCount", ackPort.size(), 2);
      if (ackPort.size() == 2) begin
         checkOutput("tieFirst", ackPort[0], 0);
         checkOutput("tieSecond", ackPort[1], 1);
         checkOutput("tieSpacing", ackEdgeLog[1] - ackEdgeLog[0], 3);
      end
      checkOutput("mem7", memArr[7], 8'h3C);

      // Write then read back on port 0; exactly one write strobe.
      opCount = 0;
      applyStimulus(0, 1'b1, 8'd5, 8'hA5);
      applyStimulus(0, 1'b0, 8'd5, 8'h00);
      waitDrain(100);
      checkOutput("rawOpCycles", opCount, 1);
      checkOutput("rawRdata", p0_rdata, 8'hA5);

      // Continuous requests from both ports alternate every three cycles.
      applyReset();
      ackPort.delete(); ackEdgeLog.delete();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1'b0, 8'($urandom_range(0, 99)), 8'h00);
         applyStimulus(1, 1'b0, 8'($urandom_range(0, 99)), 8'h00);
      end
      waitDrain(100);
      checkOutput("altCount", ackPort.size(), 4);
      if (ackPort.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput("altPort", ackPort[i], i % 2);
            if (i > 0) checkOutput("altSpacing", ackEdgeLog[i] - ackEdgeLog[i-1], 3);
         end
      end

      // Out-of-range write must not touch memory; the last valid address works.
      opCount = 0;
      saved0 = memArr[0];
      applyStimulus(1, 1'b1, 8'd100, 8'hFF);
      waitDrain(100);
      checkOutput("oorOpCycles", opCount, 0);
      checkOutput("oorMem0", memArr[0], saved0);
      checkOutput("oorErr", p1_err, 0);
      applyStimulus(1, 1'b0, 8'd99, 8'h00);
      waitDrain(100);
      checkOutput("lastAddrRdata", p1_rdata, refMem[99]);

      // No requests: nothing moves for ten cycles.
      n = ackPort.size();
      opCount = 0;
      repeat (10) @(posedge clk);
      #2;
      checkOutput("idleAcks", ackPort.size(), n);
      checkOutput("idleOpCycles", opCount, 0);

      // Reset during the ACCESS cycle of a write: write lands, no ack.
      n = ackPort.size();
      applyStimulus(0, 1'b1, 8'd2, 8'h11);
      begin
         int k = 0;
         do begin
            @(posedge clk);
            #2;
            k++;
         end while (mem_operation !== 1'b1 && k < 20);
      end
      checkOutput("rstAccessOp", mem_operation, 1);
      reset = 1'b1;
      p0_req = 1'b0;
      q0.delete();
      @(posedge clk);
      #2;
      checkOutput("rstAccessAck0", p0_ack, 0);
      checkOutput("rstAccessMemOp", mem_operation, 0);
      checkOutput("rstAccessMemAddr", mem_address, 0);
      checkOutput("rstAccessRdata0", p0_rdata, 0);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      checkOutput("rstAccessNoAck", ackPort.size(), n);
      checkOutput("mem2", memArr[2], 8'h11);

      // Randomized traffic with gaps, including out-of-range addresses.
      gapEn = 1'b1;
      for (int i = 0; i < 25; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 120)), 8'($urandom));
         applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 120)), 8'($urandom));
      end
      waitDrain(1000);
      gapEn = 1'b0;
      checkOutput("pendEmpty", pend.size(), 0);

      for (int a = 0; a < 256; a++) begin
         checkOutput("memImage", memArr[a], refMem[a]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin controller that shares the single-ported CPU data memory between the instruction-fetch unit (port 0) and the load/store unit (port 1). It accepts one request at a time, drives the memory's address/operation/write-data inputs for exactly one cycle, captures read data, and returns a one-cycle acknowledge with data and a range-error flag. It sits between the CPU core and the memory instance and is the only driver of the memory's inputs.

## Interface
- ADDR_W, 8, address width of ports and memory
- DATA_W, 8, data width
- MEM_DEPTH, 100, number of valid memory words; addresses >= MEM_DEPTH are out of range
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  request; held high with command stable until the cycle ack is high
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DATA_W  read data, valid while ack high, held until next ack on that port
- p0_err / p1_err  out  1  out-of-range flag, valid with ack
- mem_address  out  ADDR_W  memory address
- mem_operation  out  1  memory operation, 1 = write
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data (memory updates it on falling edge)

## Operation
- FSM states IDLE, ACCESS, DONE; reset -> IDLE.
- IDLE: no req -> stay. Any req -> choose winner, latch winner's we/addr/wdata, register mem outputs, -> ACCESS.
- Winner: single requester wins. Both requesting -> port not granted last. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS: mem_operation = latched we (only in this cycle); memory executes on the falling edge inside ACCESS. -> DONE, capturing mem_rdata into winner's rdata on read.
- DONE: winner's ack = 1, err per range check; req inputs ignored; -> IDLE.
- mem_operation is 0 in IDLE and DONE and after reset; the memory writes on every falling edge while it is 1, so any extra high cycle is a bug.
- Out-of-range (addr >= MEM_DEPTH): mem_operation forced 0, mem_address forced 0, rdata = 0, err = 1 with ack; memory contents unchanged.
- Write ack: rdata unchanged, err = 0.
- Loser's req stays pending and is served in the next IDLE.

## Timing
- Reset values: all acks 0, errs 0, rdata 0, mem_address 0, mem_operation 0, mem_wdata 0, last_grant 1.
- Req sampled at edge E0 (IDLE). Memory access occurs on the falling edge between E0 and E1. Ack is high in the cycle after E1. Latency is 2 cycles from sample to ack.
- Throughput: one access per 3 cycles. A requester may present a new command in the cycle after its ack; it is sampled in the following IDLE.
- Read-after-write to the same address on consecutive grants returns the new value.
- Reset asserted during ACCESS: the falling-edge write already issued completes. No ack is produced. State is IDLE after the edge.
- Reset during DONE: ack is cleared at that edge.

## Structure
- Package cpu_mem_pkg: state enum (IDLE/ACCESS/DONE), ADDR_W/DATA_W/MEM_DEPTH defaults, port index constants.
- One sub-module, arb_rr2: a two-input round-robin picker with grant index and last_grant register, updated only on IDLE -> ACCESS.

## Test plan
- p0 write addr 5 data 0xA5, then p0 read addr 5 -> second ack returns rdata 0xA5, err 0; mem_operation is high for exactly one cycle total.
- p0 and p1 both request in the first cycle after reset (p0 read 3, p1 write 7 data 0x3C) -> p0 acked first, p1 acked 3 cycles later; memory[7] = 0x3C.
- Both hold continuous requests for 12 cycles -> acks alternate 0,1,0,1, one every 3 cycles.
- p1 write addr 100 data 0xFF -> p1_ack with p1_err 1, mem_operation stays 0, memory[100 mod anything] untouched; read addr 99 is served normally with err 0.
- Reset asserted in the ACCESS cycle of a p0 write of addr 2 data 0x11 -> no p0_ack; memory[2] = 0x11; all outputs at reset values next cycle.
- Req deasserted with no pending requests -> FSM stays IDLE, mem_operation 0 and no ack for 10 cycles.
